// File: rtl/otter_pkg.sv
// Shared types, size encodings and access-legality helpers for the data memory port.
package otter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned TIMEOUT_DEF = 16;

    // Halfwords need an even address, words need a 4-byte aligned one; size 11 is illegal.
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lo[0];
            SZ_WORD: return (lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] w);
        case (size)
            SZ_BYTE: return {4{w[7:0]}};
            SZ_HALF: return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_port_if.sv
// Memory-side request/response bus between the data port and the memory.
interface mem_data_port_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              BUS_VALID;
    logic              BUS_WE;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic [3:0]        BUS_BE;
    logic [31:0]       BUS_WDATA;
    logic              BUS_READY;
    logic              BUS_RVALID;
    logic [31:0]       BUS_RDATA;

    modport master (
        output BUS_VALID, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA,
        input  BUS_READY, BUS_RVALID, BUS_RDATA
    );

    modport slave (
        input  BUS_VALID, BUS_WE, BUS_ADDR, BUS_BE, BUS_WDATA,
        output BUS_READY, BUS_RVALID, BUS_RDATA
    );
endinterface

// File: rtl/mem_load_align.sv
// Shifts a returned bus word down to the addressed byte lane and zero/sign-extends it.
module mem_load_align
    import otter_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result_c
);
    logic [31:0] shifted;

    always_comb begin
        shifted  = raw >> {offset, 3'b000};
        result_c = shifted;
        case (funct3[1:0])
            SZ_BYTE: result_c = funct3[2] ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result_c = funct3[2] ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result_c = shifted;
        endcase
    end
endmodule

// File: rtl/mem_data_port.sv
// Data-memory port: turns control-unit load/store strobes into bus transactions with stall and error reporting.
module mem_data_port
    import otter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              memRDEN2,
    input  logic              memWE2,
    input  logic [2:0]        ir14_12,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              BUSY,
    output logic              ERR,
    mem_data_port_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       aligned_c;
    logic              accept_c, reject_c;

    mem_load_align u_align (
        .raw      (bus.BUS_RDATA),
        .offset   (off_q),
        .funct3   (f3_q),
        .result_c (aligned_c)
    );

    // Request qualification happens only in IDLE; strobes elsewhere are ignored.
    always_comb begin
        accept_c = (state_q == ST_IDLE) && (memRDEN2 ^ memWE2)
                   && access_ok(ir14_12[1:0], ADDR[1:0]);
        reject_c = (state_q == ST_IDLE)
                   && ((memRDEN2 && memWE2)
                       || ((memRDEN2 ^ memWE2) && !access_ok(ir14_12[1:0], ADDR[1:0])));
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_REQ;
                    valid_d = 1'b1;
                    we_d    = memWE2;
                    addr_d  = {ADDR[ADDR_W-1:2], 2'b00};
                    be_d    = lane_mask(ir14_12[1:0], ADDR[1:0]);
                    wdata_d = lane_data(ir14_12[1:0], WDATA);
                    f3_d    = ir14_12;
                    off_d   = ADDR[1:0];
                end else if (reject_c) begin
                    err_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.BUS_READY) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.BUS_RVALID) begin
                    rdata_d = aligned_c;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // BUSY also covers the accepting IDLE cycle so the control unit stalls immediately.
    assign BUSY          = RST_N && ((state_q == ST_REQ) || (state_q == ST_WAIT) || accept_c);
    assign RDATA         = rdata_q;
    assign ERR           = err_q;
    assign bus.BUS_VALID = valid_q;
    assign bus.BUS_WE    = we_q;
    assign bus.BUS_ADDR  = addr_q;
    assign bus.BUS_BE    = be_q;
    assign bus.BUS_WDATA = wdata_q;
endmodule
